// File: rtl/cl_cosim_txn_arb.sv
// Purpose: round-robin scheduler sharing one host transaction channel among NUM_REQ co-sim
//          event sources (0 apb_wr, 1 apb_rd, 2 ram_wr, 3 ram_rd, 4 irq_wr, 5 irq_rd).
// Latency: grant in the request cycle, txn_valid next cycle, done pulse one cycle after the
//          response or timeout (minimum 4 cycles per transaction, 2 for a rejected size).
// Backpressure: one transaction outstanding; txn payload held until txn_ready; requesters
//          simply wait with req_valid high until their req_ready pulse.
// Ports: req_* packed per-requester request bus with a one-cycle req_ready capture pulse;
//        txn_* latched payload offered downstream; rsp_* downstream completion;
//        done_* one-cycle completion report; busy = not idle; stale_rsp sticky unexpected response.
module cl_cosim_txn_arb #(
   parameter int NUM_REQ     = 6,
   parameter int ADDR_W      = 64,
   parameter int DATA_W      = 64,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                      clk_main_a0,
   input  logic                      rst_main_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ-1:0]        req_wr,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ*4-1:0]      req_size,
   output logic                      txn_valid,
   input  logic                      txn_ready,
   output logic [2:0]                txn_id,
   output logic                      txn_wr,
   output logic [ADDR_W-1:0]         txn_addr,
   output logic [DATA_W-1:0]         txn_data,
   output logic [3:0]                txn_size,
   input  logic                      rsp_valid,
   input  logic [DATA_W-1:0]         rsp_data,
   input  logic                      rsp_err,
   output logic                      done_valid,
   output logic [2:0]                done_id,
   output logic [DATA_W-1:0]         done_data,
   output logic                      done_err,
   output logic                      busy,
   output logic                      stale_rsp
);

   localparam int TMR_W = $clog2(TIMEOUT_CYC);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_RSP = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [2:0]        rr_ptr;
   logic [TMR_W-1:0]  timer;
   logic [DATA_W-1:0] done_data_q;
   logic              done_err_q;

   logic              grant_hit;
   logic [2:0]        grant_idx;
   logic [2:0]        cand;
   logic              g_wr;
   logic [ADDR_W-1:0] g_addr;
   logic [DATA_W-1:0] g_data;
   logic [3:0]        g_size;
   logic              size_ok;
   logic              tmo;

   // Scan from rr_ptr upward (mod NUM_REQ). Iterating from the farthest offset down
   // lets the nearest valid requester overwrite the result last.
   always_comb begin
      grant_hit = 1'b0;
      grant_idx = '0;
      cand      = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         cand = (int'(rr_ptr) + i >= NUM_REQ) ? 3'(int'(rr_ptr) + i - NUM_REQ)
                                              : 3'(int'(rr_ptr) + i);
         if (req_valid[cand]) begin
            grant_hit = 1'b1;
            grant_idx = cand;
         end
      end
   end

   assign g_wr    = req_wr[grant_idx];
   assign g_addr  = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
   assign g_data  = req_data[int'(grant_idx)*DATA_W +: DATA_W];
   assign g_size  = req_size[int'(grant_idx)*4 +: 4];
   assign size_ok = (g_size == 4'd1) || (g_size == 4'd2) || (g_size == 4'd4) || (g_size == 4'd8);

   // Timer starts at 0 on ISSUE entry, so this fires in the TIMEOUT_CYC-th cycle after it.
   assign tmo = (timer == TMR_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      req_ready  = '0;
      txn_valid  = 1'b0;
      done_valid = 1'b0;
      done_id    = '0;
      done_data  = '0;
      done_err   = 1'b0;
      busy       = (state != IDLE);
      case (state)
         IDLE: begin
            if (grant_hit) begin
               // Gated by reset so a held req_valid cannot leak a pulse while in reset.
               req_ready[grant_idx] = rst_main_n;
               state_nxt            = size_ok ? ISSUE : DONE;
            end
         end
         ISSUE: begin
            txn_valid = 1'b1;
            // Timeout wins over a same-cycle handshake: the transaction is reported as
            // failed and any later response from downstream lands as stale.
            if (tmo) begin
               state_nxt = DONE;
            end else if (txn_ready) begin
               state_nxt = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (rsp_valid || tmo) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done_valid = 1'b1;
            done_id    = txn_id;
            done_data  = done_data_q;
            done_err   = done_err_q;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
      if (!rst_main_n) begin
         rr_ptr      <= '0;
         timer       <= '0;
         txn_id      <= '0;
         txn_wr      <= 1'b0;
         txn_addr    <= '0;
         txn_data    <= '0;
         txn_size    <= '0;
         done_data_q <= '0;
         done_err_q  <= 1'b0;
         stale_rsp   <= 1'b0;
      end else begin
         if (rsp_valid && (state != WAIT_RSP)) begin
            stale_rsp <= 1'b1;
         end
         case (state)
            IDLE: begin
               timer <= '0;
               if (grant_hit) begin
                  txn_id      <= grant_idx;
                  txn_wr      <= g_wr;
                  txn_addr    <= g_addr;
                  txn_data    <= g_data;
                  txn_size    <= g_size;
                  rr_ptr      <= (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
                  done_data_q <= '0;
                  done_err_q  <= !size_ok;
               end
            end
            ISSUE: begin
               timer <= timer + 1'b1;
               if (tmo) begin
                  done_err_q  <= 1'b1;
                  done_data_q <= '0;
               end
            end
            WAIT_RSP: begin
               timer <= timer + 1'b1;
               if (rsp_valid) begin
                  done_err_q  <= rsp_err;
                  done_data_q <= (!txn_wr && !rsp_err) ? rsp_data : '0;
               end else if (tmo) begin
                  done_err_q  <= 1'b1;
                  done_data_q <= '0;
               end
            end
            default: timer <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_cl_cosim_txn_arb.sv
// Purpose: self-checking bench for cl_cosim_txn_arb (TIMEOUT_CYC = 16).
// Directed table vectors, hand sequences for reset / round-robin / stale response,
// then randomized requests checked against a transaction-level outcome model.
module tb_cl_cosim_txn_arb;
   localparam int NR = 6;
   localparam int T  = 16;

   logic              clk;
   logic              rst_n;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR-1:0]     req_wr;
   logic [NR*64-1:0]  req_addr;
   logic [NR*64-1:0]  req_data;
   logic [NR*4-1:0]   req_size;
   logic              txn_valid;
   logic              txn_ready;
   logic [2:0]        txn_id;
   logic              txn_wr;
   logic [63:0]       txn_addr;
   logic [63:0]       txn_data;
   logic [3:0]        txn_size;
   logic              rsp_valid;
   logic [63:0]       rsp_data;
   logic              rsp_err;
   logic              done_valid;
   logic [2:0]        done_id;
   logic [63:0]       done_data;
   logic              done_err;
   logic              busy;
   logic              stale_rsp;

   int checks;
   int errors;

   cl_cosim_txn_arb #(.NUM_REQ(NR), .ADDR_W(64), .DATA_W(64), .TIMEOUT_CYC(T)) dut (
      .clk_main_a0(clk), .rst_main_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
      .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_id(txn_id), .txn_wr(txn_wr),
      .txn_addr(txn_addr), .txn_data(txn_data), .txn_size(txn_size),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .done_valid(done_valid), .done_id(done_id), .done_data(done_data), .done_err(done_err),
      .busy(busy), .stale_rsp(stale_rsp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   typedef struct {
      int          g;
      logic        wr;
      logic [63:0] addr;
      logic [63:0] data;
      logic [3:0]  size;
      int          d_r;     // ISSUE cycle (0 = entry) on which txn_ready is offered
      int          d_s;     // extra cycles after the handshake before rsp_valid
      logic [63:0] rdata;
      logic        rerr;
      int          c_done;  // expected done cycle, counted from the grant cycle (0)
      logic        err;
      logic [63:0] dat;
   } vec_t;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic wr, input logic [63:0] a,
                          input logic [63:0] d, input logic [3:0] s);
      req_wr[i]          = wr;
      req_addr[i*64 +: 64] = a;
      req_data[i*64 +: 64] = d;
      req_size[i*4 +: 4]   = s;
   endtask

   // Round-robin rule: lowest set bit of the mask rotated so that bit p comes first.
   function automatic int rr_pick(input logic [NR-1:0] m, input int p);
      logic [2*NR-1:0] dbl;
      dbl = {m, m} >> p;
      for (int k = 0; k < NR; k++) begin
         if (dbl[k]) return (p + k) % NR;
      end
      return -1;
   endfunction

   // Transaction outcome from the responder timing: ISSUE entry is grant+1, the done
   // pulse follows the completing cycle, and the timer allows cycles 0..T-1 of ISSUE/WAIT.
   function automatic void predict(input logic wr, input logic [3:0] sz, input int d_r,
                                   input int d_s, input logic [63:0] rd, input logic re,
                                   output int c_done, output logic err, output logic [63:0] dat);
      if (!(sz == 4'd1 || sz == 4'd2 || sz == 4'd4 || sz == 4'd8)) begin
         c_done = 1; err = 1'b1; dat = '0;
      end else if (d_r >= T - 1 || d_r + 1 + d_s > T - 1) begin
         c_done = T + 1; err = 1'b1; dat = '0;
      end else begin
         c_done = d_r + 1 + d_s + 2;
         err    = re;
         dat    = (!wr && !re) ? rd : 64'h0;
      end
   endfunction

   // Called in an IDLE cycle with the request inputs already applied.
   task automatic run_one(input int g, input logic wr, input logic [63:0] addr,
                          input logic [63:0] data, input logic [3:0] size, input int d_r,
                          input int d_s, input logic [63:0] rdata, input logic rerr,
                          input int c_done, input logic exp_err, input logic [63:0] exp_dat,
                          input bit keep);
      bit vsz, drv, early, extra, tvbad;
      int rsp_at;
      logic [NR-1:0] oh;
      vsz    = (size == 4'd1) || (size == 4'd2) || (size == 4'd4) || (size == 4'd8);
      rsp_at = d_r + 1 + d_s;
      drv    = vsz && (d_r < T - 1) && (rsp_at <= T - 1);
      early  = 1'b0; extra = 1'b0; tvbad = 1'b0;
      oh     = '0;
      oh[g]  = 1'b1;
      #1;
      chk("grant_ready", 256'(req_ready), 256'(oh));
      tick();
      if (!keep) req_valid[g] = 1'b0;
      for (int c = 1; c <= c_done; c++) begin
         int r;
         r = c - 1;
         txn_ready = vsz && (r == d_r);
         rsp_valid = drv && (r == rsp_at);
         rsp_data  = rdata;
         rsp_err   = rerr;
         #1;
         if (c == 1 && vsz)
            chk("txn_payload", 256'({txn_id, txn_wr, txn_addr, txn_data, txn_size}),
                256'({3'(g), wr, addr, data, size}));
         if (txn_valid !== (vsz && r <= d_r && r <= T - 1 && c < c_done)) tvbad = 1'b1;
         if (req_ready !== '0) extra = 1'b1;
         if (c < c_done && done_valid !== 1'b0) early = 1'b1;
         if (c == c_done)
            chk("done_fields", 256'({done_valid, done_id, done_err, done_data}),
                256'({1'b1, 3'(g), exp_err, exp_dat}));
         tick();
      end
      txn_ready = 1'b0;
      rsp_valid = 1'b0;
      chk("done_single_pulse", 256'({done_valid, busy}), 256'(0));
      chk("no_early_done", 256'(early), 256'(0));
      chk("txn_valid_window", 256'(tvbad), 256'(0));
      chk("no_extra_ready", 256'(extra), 256'(0));
   endtask

   vec_t        vec[10];
   int          ptr_m;
   int          g, d_r, d_s, cd;
   logic [NR-1:0] mask;
   logic        e, wr_r, re_r;
   logic [63:0] dt, a_r, d_r64, rd_r;
   logic [31:0] lo, hi;
   logic [3:0]  sz;
   bit          dv_seen;

   initial begin
      //          g  wr    addr          data          sz    dr  ds  rdata                  re    c   err   dat
      vec[0] = '{0, 1'b1, 64'h1000, 64'hCAFE, 4'd4, 0,  1, 64'h0,                  1'b0, 4,  1'b0, 64'h0};
      vec[1] = '{4, 1'b0, 64'h2000, 64'h0,    4'd8, 0,  0, 64'h1122334455667788,   1'b0, 3,  1'b0, 64'h1122334455667788};
      vec[2] = '{4, 1'b0, 64'h2008, 64'h0,    4'd8, 0,  0, 64'h1122334455667788,   1'b1, 3,  1'b1, 64'h0};
      vec[3] = '{3, 1'b1, 64'h3000, 64'h55,   4'd2, 3,  2, 64'hDEAD,               1'b0, 8,  1'b0, 64'h0};
      vec[4] = '{1, 1'b0, 64'h4000, 64'h0,    4'd1, 2, 20, 64'hBEEF,               1'b0, 17, 1'b1, 64'h0};
      vec[5] = '{5, 1'b0, 64'h5000, 64'h0,    4'd8, 15, 0, 64'h1,                  1'b0, 17, 1'b1, 64'h0};
      vec[6] = '{2, 1'b1, 64'h6000, 64'h77,   4'd3, 0,  0, 64'h0,                  1'b0, 1,  1'b1, 64'h0};
      vec[7] = '{0, 1'b0, 64'h7000, 64'h0,    4'd8, 0, 14, 64'hA5A5,               1'b0, 17, 1'b0, 64'hA5A5};
      vec[8] = '{0, 1'b0, 64'h7008, 64'h0,    4'd8, 0, 15, 64'hA5A5,               1'b0, 17, 1'b1, 64'h0};
      vec[9] = '{1, 1'b1, 64'h9000, 64'h9,    4'd0, 0,  0, 64'h0,                  1'b0, 1,  1'b1, 64'h0};

      checks = 0; errors = 0;
      rst_n = 1'b0;
      txn_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; rsp_err = 1'b0;
      req_wr = '0; req_addr = '0; req_data = '0; req_size = '0;
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, 64'h100 * i, 64'(i), 4'd4);
      req_valid = '1;

      // Reset state, with every requester asking.
      #2;
      chk("reset_outputs", 256'({req_ready, txn_valid, txn_id, txn_wr, txn_addr, txn_data, txn_size,
                                 done_valid, done_id, done_data, done_err, busy, stale_rsp}), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;

      // All six held: grants 0..5 then wrap to 0.
      for (int k = 0; k < 7; k++)
         run_one(k % NR, 1'b1, 64'h100 * (k % NR), 64'(k % NR), 4'd4, 0, 0, 64'h0, 1'b0,
                 3, 1'b0, 64'h0, 1'b1);

      // Directed table.
      for (int k = 0; k < 10; k++) begin
         req_valid = '0;
         set_req(vec[k].g, vec[k].wr, vec[k].addr, vec[k].data, vec[k].size);
         req_valid[vec[k].g] = 1'b1;
         run_one(vec[k].g, vec[k].wr, vec[k].addr, vec[k].data, vec[k].size, vec[k].d_r,
                 vec[k].d_s, vec[k].rdata, vec[k].rerr, vec[k].c_done, vec[k].err, vec[k].dat, 1'b0);
      end

      // Late response after the timeouts above arrives while idle.
      chk("stale_clear_before", 256'(stale_rsp), 256'(0));
      rsp_valid = 1'b1;
      tick();
      rsp_valid = 1'b0;
      chk("stale_set", 256'(stale_rsp), 256'(1));
      tick();
      chk("stale_sticky", 256'(stale_rsp), 256'(1));

      // Reset while waiting for a response on requester 3 (rr_ptr moves to 4).
      req_valid = '0;
      set_req(3, 1'b0, 64'h8000, 64'h0, 4'd8);
      req_valid[3] = 1'b1;
      #1;
      chk("mid_grant", 256'(req_ready), 256'(6'b001000));
      tick();
      req_valid = '0;
      txn_ready = 1'b1;
      tick();
      txn_ready = 1'b0;
      #1;
      chk("mid_in_wait", 256'({busy, txn_valid}), 256'(2'b10));
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, 64'h100 * i, 64'(i), 4'd4);
      req_valid = '1;
      rst_n = 1'b0;
      #1;
      chk("reset_async_outputs", 256'({req_ready, txn_valid, txn_id, txn_wr, txn_addr, txn_data, txn_size,
                                       done_valid, done_id, done_data, done_err, busy, stale_rsp}), 256'(0));
      dv_seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (done_valid !== 1'b0) dv_seen = 1'b1;
      end
      chk("reset_no_done", 256'(dv_seen), 256'(0));
      #3;
      rst_n = 1'b1;
      run_one(0, 1'b1, 64'h0, 64'h0, 4'd4, 0, 0, 64'h0, 1'b0, 3, 1'b0, 64'h0, 1'b0);
      ptr_m = 1;

      // Randomized requests against the outcome model.
      for (int n = 0; n < 40; n++) begin
         mask = NR'($urandom_range(1, (1 << NR) - 1));
         for (int i = 0; i < NR; i++) begin
            lo = $urandom; hi = $urandom;
            case ($urandom_range(0, 7))
               0:       sz = 4'd3;
               1:       sz = 4'd0;
               2:       sz = 4'd1;
               3:       sz = 4'd2;
               4, 5:    sz = 4'd4;
               default: sz = 4'd8;
            endcase
            set_req(i, 1'($urandom_range(0, 1)), {hi, lo}, {lo, hi}, sz);
         end
         req_valid = mask;
         g    = rr_pick(mask, ptr_m);
         d_r  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(12, 16)) : int'($urandom_range(0, 3));
         d_s  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(10, 16)) : int'($urandom_range(0, 4));
         lo = $urandom; hi = $urandom;
         rd_r = {hi, lo};
         re_r = ($urandom_range(0, 4) == 0);
         wr_r  = req_wr[g];
         a_r   = req_addr[g*64 +: 64];
         d_r64 = req_data[g*64 +: 64];
         sz    = req_size[g*4 +: 4];
         predict(wr_r, sz, d_r, d_s, rd_r, re_r, cd, e, dt);
         run_one(g, wr_r, a_r, d_r64, sz, d_r, d_s, rd_r, re_r, cd, e, dt, 1'b0);
         ptr_m = (g + 1) % NR;
      end
      chk("stale_quiet_random", 256'(stale_rsp), 256'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
